// File: rtl/hov_loader_pkg.sv
// Shared types and constants for the host-driven input loader.
// Holds the loader FSM state encoding, the host command bytes and default widths.
// No logic; imported by input_loader.
package hov_loader_pkg;

  // Default geometry of the input arrays
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 12;

  // Host command bytes, only interpreted while the loader is idle
  localparam logic [7:0] CMD_LOAD1 = 8'h01;
  localparam logic [7:0] CMD_LOAD2 = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h10;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_LO  = 3'd1,
    CNT_HI  = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    WRITE   = 3'd5
  } state_e;

endpackage

// File: rtl/input_loader.sv
// Byte-stream loader: decodes host commands, fills input arrays 1/2, controls CPU reset/start.
// Latency: array write strobes one cycle after the hi byte of each word is accepted.
// Backpressure: rx_ready drops only in the one-cycle WRITE state and while rst is high.
// Optional: define LOADER_INPUT2_EN to make command 0x02 load array 2; otherwise 0x02 is an unknown command.
// ADDR_W must be in 9..16 and DATA_W in 9..16 (both are assembled from two bytes).
module input_loader
  import hov_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              in1_write,
  output logic              in2_write,
  output logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] len1,
  output logic [ADDR_W-1:0] len2,
  output logic              cpu_rst,
  output logic              cpu_start,
  output logic              busy,
  output logic              cmd_err
);

`ifdef LOADER_INPUT2_EN
  localparam bit IN2_EN = 1'b1;
`else
  localparam bit IN2_EN = 1'b0;
`endif

  // Registered state
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;   // words in the current load
  logic [ADDR_W-1:0] idx_q, idx_d;       // index of the word being assembled
  logic [7:0]        lo_q, lo_d;         // low byte of the word in flight
  logic              sel2_q, sel2_d;     // current load targets array 2
  logic [ADDR_W-1:0] len1_q, len1_d;
  logic [ADDR_W-1:0] len2_q, len2_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              cpu_start_q, cpu_start_d;
  logic              wr1_q, wr1_d;
  logic              wr2_q, wr2_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Byte handshake and decode helpers
  logic              accept;
  logic              load1_cmd;
  logic              load2_cmd;
  logic [ADDR_W-1:0] cnt_full;
  logic [DATA_W-1:0] word;
  logic [ADDR_W:0]   idx_next;
  logic              last_word;

  assign rx_ready  = (state_q != WRITE) && !rst;
  assign accept    = rx_valid && rx_ready;
  assign load1_cmd = (rx_data == CMD_LOAD1);
  assign load2_cmd = IN2_EN && (rx_data == CMD_LOAD2);
  // Upper count bits beyond ADDR_W in the hi byte are ignored
  assign cnt_full  = {rx_data[ADDR_W-9:0], count_q[7:0]};
  assign word      = {rx_data[DATA_W-9:0], lo_q};
  // One extra bit so the compare cannot wrap even at the maximum count
  assign idx_next  = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (idx_next >= {1'b0, count_q});

  // Next-state and datapath decode for the loader FSM
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    sel2_d      = sel2_q;
    len1_d      = len1_q;
    len2_d      = len2_q;
    err_d       = err_q;
    cpu_rst_d   = cpu_rst_q;
    cpu_start_d = 1'b0;
    wr1_d       = 1'b0;
    wr2_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (load1_cmd || load2_cmd) begin
            state_d   = CNT_LO;
            sel2_d    = load2_cmd;
            idx_d     = '0;
            cpu_rst_d = 1'b1;
          end else if (rx_data == CMD_RUN) begin
            cpu_rst_d   = 1'b0;
            cpu_start_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CNT_LO: begin
        if (accept) begin
          count_d = {{(ADDR_W-8){1'b0}}, rx_data};
          state_d = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          count_d = cnt_full;
          if (cnt_full == '0) begin
            // Empty load completes immediately and records a zero length
            state_d = IDLE;
            if (sel2_q) len2_d = '0;
            else        len1_d = '0;
          end else begin
            state_d = DATA_LO;
          end
        end
      end
      DATA_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (accept) begin
          wr1_d   = !sel2_q;
          wr2_d   = sel2_q;
          addr_d  = idx_q;
          data_d  = word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Write strobe is on the outputs this cycle; no byte is taken
        idx_d = idx_next[ADDR_W-1:0];
        if (last_word) begin
          state_d = IDLE;
          if (sel2_q) len2_d = count_q;
          else        len1_d = count_q;
        end else begin
          state_d = DATA_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      lo_q        <= '0;
      sel2_q      <= 1'b0;
      len1_q      <= '0;
      len2_q      <= '0;
      err_q       <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_start_q <= 1'b0;
      wr1_q       <= 1'b0;
      wr2_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      sel2_q      <= sel2_d;
      len1_q      <= len1_d;
      len2_q      <= len2_d;
      err_q       <= err_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_start_q <= cpu_start_d;
      wr1_q       <= wr1_d;
      wr2_q       <= wr2_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign in1_write = wr1_q;
  assign in2_write = IN2_EN ? wr2_q : 1'b0;
  assign len1      = len1_q;
  assign len2      = IN2_EN ? len2_q : '0;
  assign addr_in   = addr_q;
  assign data_in   = data_q;
  assign cpu_rst   = cpu_rst_q;
  assign cpu_start = cpu_start_q;
  assign busy      = (state_q != IDLE);
  assign cmd_err   = err_q;

endmodule
